// File: rtl/demux_pkg.sv
// Shared constants and state encoding for the 1-to-4 demux sequencer.
package demux_pkg;
  localparam int unsigned NCH  = 4;
  localparam int unsigned SELW = 2;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;
endpackage

// File: rtl/rr_next_enabled.sv
// Finds the next enabled channel, starting at base (incl_base=1) or just after it,
// wrapping; with incl_base=0 the base itself is the last candidate.
module rr_next_enabled
  import demux_pkg::*;
(
  input  logic [SELW-1:0] base,
  input  logic [NCH-1:0]  en,
  input  logic            incl_base,
  output logic [SELW-1:0] nxt,
  output logic            any
);

  always_comb begin
    logic            found;
    logic [SELW-1:0] idx;
    int unsigned     off;
    nxt   = base;
    found = 1'b0;
    idx   = '0;
    off   = 0;
    for (int unsigned k = 0; k < NCH; k++) begin
      off = incl_base ? k : k + 1;
      idx = base + SELW'(off);
      if (!found && en[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end

  assign any = |en;

endmodule

// File: rtl/demux_rr_scheduler.sv
// Single-register sequencer distributing one valid/ready stream over 4 channels,
// weighted round-robin (BURST words per channel) or fixed select.
module demux_rr_scheduler
  import demux_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned BURST = 4,
  parameter int unsigned CW    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [W-1:0]    in_data,
  output logic            in_ready,
  input  logic            mode,
  input  logic [SELW-1:0] fixed_sel,
  input  logic [NCH-1:0]  chan_en,
  output logic [NCH-1:0]  out_valid,
  output logic [W-1:0]    out_data,
  input  logic [NCH-1:0]  out_ready,
  output logic [SELW-1:0] cur_sel
);

  localparam logic [CW-1:0] BEAT_LAST = CW'(BURST - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0] out_sel_q, out_sel_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            init_q;

  logic [SELW-1:0] rr_tgt, rot_nxt, tgt;
  logic            rr_any, rot_any, tgt_ok;
  logic            accept, pop, full;

  rr_next_enabled u_tgt (
    .base      (ptr_q),
    .en        (chan_en),
    .incl_base (1'b1),
    .nxt       (rr_tgt),
    .any       (rr_any)
  );

  rr_next_enabled u_rot (
    .base      (tgt),
    .en        (chan_en),
    .incl_base (1'b0),
    .nxt       (rot_nxt),
    .any       (rot_any)
  );

  assign full   = (state_q == ST_FULL);
  assign tgt    = (mode == MODE_FIXED) ? fixed_sel : rr_tgt;
  assign tgt_ok = (mode == MODE_FIXED) ? chan_en[fixed_sel] : rr_any;

  // init_q keeps in_ready low until the first edge after reset release.
  assign in_ready  = init_q & tgt_ok & (!full | out_ready[out_sel_q]);
  assign accept    = in_valid & in_ready;
  assign pop       = full & out_ready[out_sel_q];
  assign out_valid = full ? NCH'(1 << out_sel_q) : '0;
  assign out_data  = out_data_q;
  assign cur_sel   = tgt;

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_sel_d  = out_sel_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    if (accept) begin
      state_d    = ST_FULL;
      out_data_d = in_data;
      out_sel_d  = tgt;
      if (mode == MODE_FIXED) begin
        beat_cnt_d = '0;
        ptr_d      = fixed_sel;
      end else if (beat_cnt_q == BEAT_LAST) begin
        beat_cnt_d = '0;
        ptr_d      = rot_any ? rot_nxt : tgt;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
        ptr_d      = tgt;
      end
    end else if (pop) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      out_sel_q  <= '0;
      ptr_q      <= '0;
      beat_cnt_q <= '0;
      init_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_sel_q  <= out_sel_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
      init_q     <= 1'b1;
    end
  end

endmodule
